// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: BOOT/RUN/BUBBLE sequencing of the fetch-group address
// with BTB-predicted targets, backend redirects and a saturating redirect counter.
module fetch_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] bta,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        fetch_ready,
   output logic [31:0] pc,
   output logic        pc_valid,
   output logic [1:0]  inst_count,
   output logic        pred_taken,
   output logic [15:0] redirect_cnt
);

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_BUBBLE = 2'd2;

   localparam logic [31:0] BOOT_PC = {RESET_PC[31:2], 2'b00};

   logic [1:0]  state, state_nxt;
   logic [31:0] pc_nxt, seq_pc, pred_pc;
   logic        xfer;

   assign pc_valid   = (state == ST_RUN);
   assign pred_taken = pc_valid && (bta != pc);
   assign inst_count = !pc_valid ? 2'd0 : (pc[2] ? 2'd1 : 2'd2);
   assign xfer       = pc_valid && fetch_ready;

   // 29-bit increment drops the carry, so the last two words wrap to 0
   assign seq_pc  = {pc[31:3] + 29'd1, 3'b000};
   assign pred_pc = {bta[31:2], 2'b00};

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      if (redirect_valid) begin
         state_nxt = ST_BUBBLE;
         pc_nxt    = {redirect_pc[31:2], 2'b00};
      end else begin
         case (state)
            ST_BOOT: begin
               state_nxt = ST_RUN;
               pc_nxt    = BOOT_PC;
            end
            ST_BUBBLE: state_nxt = ST_RUN;
            ST_RUN: begin
               if (xfer) pc_nxt = pred_taken ? pred_pc : seq_pc;
            end
            default: begin
               state_nxt = ST_BOOT;
               pc_nxt    = BOOT_PC;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_BOOT;
         pc           <= BOOT_PC;
         redirect_cnt <= 16'd0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (redirect_valid && (redirect_cnt != 16'hFFFF))
            redirect_cnt <= redirect_cnt + 16'd1;
      end
   end

endmodule
